// File: rtl/mul_div_unit.sv
// Multi-cycle shift-add multiplier / restoring divider with HI/LO registers.
// One bit per cycle; signed ops run on magnitudes and are corrected at the end.
module mul_div_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  input  logic             hilo_rd_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   a_q, rem_q, hi_q, lo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               div_q, neg_q, neg_r_q, dz_q, done_q;

  logic               sgn, rs_neg, rt_neg, accept, ge;
  logic [WIDTH-1:0]   rs_abs, rt_abs, madd, diff, quo, rmd;
  logic [WIDTH:0]     msum, shl;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sgn    = ~op_i[0];
    rs_neg = sgn & rs_i[WIDTH-1];
    rt_neg = sgn & rt_i[WIDTH-1];
    rs_abs = rs_neg ? -rs_i : rs_i;
    rt_abs = rt_neg ? -rt_i : rt_i;
    accept = valid_i & ~flush_i;
    madd   = acc_q[0] ? a_q : {WIDTH{1'b0}};
    msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, madd};
    shl    = {rem_q, acc_q[WIDTH-1]};
    ge     = shl >= {1'b0, a_q};
    // when ge holds the true difference is below a_q, so WIDTH bits suffice
    diff   = shl[WIDTH-1:0] - a_q;
    prod   = neg_q ? -acc_q : acc_q;
    quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rmd    = neg_r_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (flush_i) state_d = IDLE;
        else if (cnt_q == CNT_W'(1)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q   <= '0;
      a_q     <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (accept) begin
            div_q   <= op_i[1];
            neg_q   <= rs_neg ^ rt_neg;
            neg_r_q <= rs_neg;
            dz_q    <= (rt_i == '0);
            cnt_q   <= CNT_W'(WIDTH);
            rem_q   <= '0;
            // a_q holds the addend / divisor, acc low half the bits consumed
            a_q     <= op_i[1] ? rt_abs : rs_abs;
            acc_q   <= {{WIDTH{1'b0}}, op_i[1] ? rs_abs : rt_abs};
          end
        end
        RUN: begin
          if (!flush_i) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (div_q) begin
              rem_q <= ge ? diff : shl[WIDTH-1:0];
              acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge};
            end else begin
              acc_q <= {msum, acc_q[WIDTH-1:1]};
            end
          end
        end
        FIN: begin
          if (!flush_i) begin
            done_q <= 1'b1;
            if (div_q) begin
              hi_q <= rmd;
              lo_q <= dz_q ? {WIDTH{1'b1}} : quo;
            end else begin
              {hi_q, lo_q} <= prod;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign stall_o = busy_o & (valid_i | hilo_rd_i | hi_we_i | lo_we_i);
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI:LO queued at issue,
// popped on each done_o pulse.
module tb_mul_div_unit;

  logic        clk, rst_n;
  logic        valid, flush, hilo_rd, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] rs, rt, wdata;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;
  logic [63:0] sb[$];

  mul_div_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .op_i(op),
    .rs_i(rs), .rt_i(rt), .flush_i(flush), .hilo_rd_i(hilo_rd),
    .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
    .busy_o(busy), .stall_o(stall), .done_o(done),
    .hi_o(hi), .lo_o(lo)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("hi", {32'b0, hi}, {32'b0, e[63:32]});
        chk("lo", {32'b0, lo}, {32'b0, e[31:0]});
      end
    end
  end

  function automatic logic [63:0] model(logic [1:0] o, logic [31:0] a,
                                        logic [31:0] b);
    longint p;
    int q, r;
    unique case (o)
      2'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'd1: return {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic issue(logic [1:0] o, logic [31:0] a, logic [31:0] b,
                       logic [63:0] e, bit push);
    @(negedge clk);
    valid = 1; op = o; rs = a; rt = b;
    if (push) sb.push_back(e);
    @(negedge clk);
    valid = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic run(logic [1:0] o, logic [31:0] a, logic [31:0] b,
                     logic [63:0] e);
    int n;
    issue(o, a, b, e, 1);
    wait_idle(n);
    chk("busy_len", n, 33);
  endtask

  initial begin
    int n, bad, dc0;
    logic [1:0] o;
    logic [31:0] a, b;
    rst_n = 0; valid = 0; flush = 0; hilo_rd = 0;
    hi_we = 0; lo_we = 0; op = 0; rs = 0; rt = 0; wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_ctl", {busy, stall, done}, 0);
    rst_n = 1;

    dc0 = done_cnt;
    run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    chk("done_once", done_cnt - dc0, 1);
    chk("done_low", done, 0);

    run(2'd0, -32'sd7, 32'd3, 64'hFFFFFFFF_FFFFFFEB);
    run(2'd2, -32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run(2'd3, 32'd100, 32'd0, {32'd100, 32'hFFFFFFFF});
    run(2'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run(2'd2, 32'hFFFFFF9C, 32'd0, 64'hFFFFFF9C_FFFFFFFF);

    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 2) ? $urandom : 32'($urandom_range(1, 300));
      if (b == 0) b = 1;
      if (i == 3) a = 32'h80000000;
      if (o == 2'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 3;
      run(o, a, b, model(o, a, b));
    end

    issue(2'd3, 32'd50, 32'd7, {32'd1, 32'd7}, 1);
    hilo_rd = 1;
    n = 0; bad = 0;
    while (busy && n < 100) begin
      if (!stall) bad++;
      n++;
      @(negedge clk);
    end
    chk("stall_hold", bad, 0);
    chk("stall_rel", stall, 0);
    chk("rd_hi", hi, 1);
    chk("rd_lo", lo, 7);
    hilo_rd = 0;

    @(negedge clk);
    hi_we = 1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 0;
    chk("mthi", hi, 32'h1234);
    dc0 = done_cnt;
    issue(2'd1, 32'd5, 32'd5, 0, 0);
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_idle", busy, 0);
    chk("flush_hi", hi, 32'h1234);
    chk("flush_lo", lo, 7);
    repeat (2) @(negedge clk);
    chk("flush_nodone", done_cnt - dc0, 0);
    run(2'd1, 32'd5, 32'd5, 64'd25);

    @(negedge clk);
    valid = 1; op = 2'd1; rs = 3; rt = 4; lo_we = 1; wdata = 32'hAAAA;
    sb.push_back(64'd12);
    @(negedge clk);
    valid = 0; lo_we = 0;
    chk("mtlo_issue", lo, 32'hAAAA);
    chk("mtlo_busy", busy, 1);
    wait_idle(n);
    chk("ovw_lo", lo, 12);

    issue(2'd1, 32'd9, 32'd9, 0, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_lo", lo, 0);
    chk("arst_ctl", {busy, stall, done}, 0);
    @(negedge clk);
    rst_n = 1;
    run(2'd3, 32'd50, 32'd7, {32'd1, 32'd7});

    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
